// File: rtl/rv_pkg.sv
// Shared RV32I encoding constants and the ALU-control code set.
// The instruction decoder uses the same codes, so the encoder is its inverse.
package rv_pkg;

   localparam logic [6:0] OP_R = 7'h33;
   localparam logic [6:0] OP_I = 7'h13;

   typedef enum logic [3:0] {
      AluAnd     = 4'b0000,
      AluSll     = 4'b0001,
      AluAdd     = 4'b0010,
      AluOr      = 4'b0011,
      AluSub     = 4'b0100,
      AluSlt     = 4'b0101,
      AluXor     = 4'b0110,
      AluSltu    = 4'b0111,
      AluSrl     = 4'b1000,
      AluSra     = 4'b1001,
      AluInvalid = 4'b1111
   } alu_ctl_e;

   localparam logic [2:0] F3_ADD  = 3'd0;
   localparam logic [2:0] F3_SLL  = 3'd1;
   localparam logic [2:0] F3_SLT  = 3'd2;
   localparam logic [2:0] F3_SLTU = 3'd3;
   localparam logic [2:0] F3_XOR  = 3'd4;
   localparam logic [2:0] F3_SR   = 3'd5;
   localparam logic [2:0] F3_OR   = 3'd6;
   localparam logic [2:0] F3_AND  = 3'd7;

   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;

   // True when v is representable as a sign-extended 12-bit immediate.
   function automatic logic fits_simm12(input logic [31:0] v);
      return (&v[31:11]) | ~(|v[31:11]);
   endfunction

endpackage

// File: rtl/enc_fifo.sv
// Synchronous FIFO with registered occupancy count and full/empty flags.
module enc_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == (AW + 1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + (AW + 1)'(1);
      else if (do_pop && !do_push) count_d = count_q - (AW + 1)'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; validity is tracked by count_q.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/inst_encoder.sv
// Encodes RV32I ALU requests into instruction words and streams them to
// instruction memory with sequential addresses.
module inst_encoder
   import rv_pkg::*;
#(
   parameter int unsigned DEPTH      = 4,
   parameter logic [31:0] RESET_ADDR = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_imm,
   input  logic [3:0]  req_alu_control,
   input  logic [4:0]  req_rd,
   input  logic [4:0]  req_rs1,
   input  logic [4:0]  req_rs2,
   input  logic [31:0] req_imm,
   input  logic        base_load,
   input  logic [31:0] base_addr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_addr,
   output logic        err,
   output logic [7:0]  err_count
);

   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic        op_ok, is_shift, imm_ok, enc_ok;
   logic [31:0] enc_word;
   logic        accept, push, pop, full, empty;
   logic [31:0] head;
   logic [$clog2(DEPTH):0] fifo_count;
   logic [31:0] addr_q, addr_d;
   logic        err_q, err_d;
   logic [7:0]  err_count_q, err_count_d;

   always_comb begin
      funct3   = F3_ADD;
      funct7   = F7_BASE;
      op_ok    = 1'b0;
      is_shift = 1'b0;
      if (!req_is_imm) begin
         unique case (req_alu_control)
            AluAdd:  begin op_ok = 1'b1; funct3 = F3_ADD;                   end
            AluSub:  begin op_ok = 1'b1; funct3 = F3_ADD; funct7 = F7_ALT;  end
            AluSll:  begin op_ok = 1'b1; funct3 = F3_SLL;                   end
            AluSlt:  begin op_ok = 1'b1; funct3 = F3_SLT;                   end
            AluSltu: begin op_ok = 1'b1; funct3 = F3_SLTU;                  end
            AluXor:  begin op_ok = 1'b1; funct3 = F3_XOR;                   end
            default: op_ok = 1'b0;
         endcase
      end else begin
         unique case (req_alu_control)
            AluAdd:  begin op_ok = 1'b1; funct3 = F3_ADD;                   end
            AluSll:  begin op_ok = 1'b1; funct3 = F3_SLL; is_shift = 1'b1;  end
            AluSlt:  begin op_ok = 1'b1; funct3 = F3_SLT;                   end
            AluSltu: begin op_ok = 1'b1; funct3 = F3_SLTU;                  end
            AluXor:  begin op_ok = 1'b1; funct3 = F3_XOR;                   end
            AluSrl:  begin op_ok = 1'b1; funct3 = F3_SR;  is_shift = 1'b1;  end
            AluSra:  begin
               op_ok = 1'b1; funct3 = F3_SR; is_shift = 1'b1; funct7 = F7_ALT;
            end
            AluOr:   begin op_ok = 1'b1; funct3 = F3_OR;                    end
            AluAnd:  begin op_ok = 1'b1; funct3 = F3_AND;                   end
            default: op_ok = 1'b0;
         endcase
      end

      imm_ok = 1'b1;
      if (req_is_imm) imm_ok = is_shift ? ~(|req_imm[31:5]) : fits_simm12(req_imm);
      enc_ok = op_ok & imm_ok;

      if (!req_is_imm)  enc_word = {funct7, req_rs2, req_rs1, funct3, req_rd, OP_R};
      else if (is_shift) enc_word = {funct7, req_imm[4:0], req_rs1, funct3, req_rd, OP_I};
      else               enc_word = {req_imm[11:0], req_rs1, funct3, req_rd, OP_I};
   end

   assign req_ready = ~full;
   assign accept    = req_valid & req_ready;
   assign push      = accept & enc_ok;
   assign out_valid = ~empty;
   assign pop       = out_valid & out_ready;

   enc_fifo #(
      .WIDTH (32),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (enc_word),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   always_comb begin
      addr_d      = addr_q;
      err_d       = accept & ~enc_ok;
      err_count_d = err_count_q;
      // A base load overrides the post-pop increment.
      if (base_load) addr_d = base_addr;
      else if (pop)  addr_d = addr_q + 32'd4;
      if (err_d && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q      <= RESET_ADDR;
         err_q       <= 1'b0;
         err_count_q <= '0;
      end else begin
         addr_q      <= addr_d;
         err_q       <= err_d;
         err_count_q <= err_count_d;
      end
   end

   assign out_inst  = out_valid ? head : '0;
   assign out_addr  = addr_q;
   assign err       = err_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed scenarios plus randomized
// traffic compared against an arithmetic reference model.
module tb_inst_encoder;

   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] RESET_ADDR = 32'h0;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_is_imm;
   logic [3:0]  req_alu_control;
   logic [4:0]  req_rd, req_rs1, req_rs2;
   logic [31:0] req_imm;
   logic        base_load;
   logic [31:0] base_addr;
   logic        out_valid, out_ready;
   logic [31:0] out_inst, out_addr;
   logic        err;
   logic [7:0]  err_count;

   int n_pass = 0;
   int n_total = 0;

   // Reference model state
   logic [31:0] exp_q[$];
   logic [31:0] m_addr;
   bit          m_err;
   int          m_cnt;

   always #5 clk = ~clk;

   inst_encoder #(
      .DEPTH      (DEPTH),
      .RESET_ADDR (RESET_ADDR)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_is_imm      (req_is_imm),
      .req_alu_control (req_alu_control),
      .req_rd          (req_rd),
      .req_rs1         (req_rs1),
      .req_rs2         (req_rs2),
      .req_imm         (req_imm),
      .base_load       (base_load),
      .base_addr       (base_addr),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_inst        (out_inst),
      .out_addr        (out_addr),
      .err             (err),
      .err_count       (err_count)
   );

   // Field-weighted sum of the RV32I instruction fields.
   function automatic void ref_encode(input bit is_imm, input logic [3:0] ctl,
                                      input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [31:0] imm,
                                      output bit ok, output logic [31:0] w);
      longint f3, f7, v, s;
      bit known, shift;
      known = 1; shift = 0; f3 = 0; f7 = 0;
      if (!is_imm) begin
         case (ctl)
            4'd2: f3 = 0;
            4'd4: begin f3 = 0; f7 = 32; end
            4'd1: f3 = 1;
            4'd5: f3 = 2;
            4'd7: f3 = 3;
            4'd6: f3 = 4;
            default: known = 0;
         endcase
      end else begin
         case (ctl)
            4'd2: f3 = 0;
            4'd1: begin f3 = 1; shift = 1; end
            4'd5: f3 = 2;
            4'd7: f3 = 3;
            4'd6: f3 = 4;
            4'd8: begin f3 = 5; shift = 1; end
            4'd9: begin f3 = 5; shift = 1; f7 = 32; end
            4'd3: f3 = 6;
            4'd0: f3 = 7;
            default: known = 0;
         endcase
      end
      ok = known;
      v = longint'(rs1) * 32768 + f3 * 4096 + longint'(rd) * 128;
      if (!is_imm) begin
         v = v + f7 * 33554432 + longint'(rs2) * 1048576 + 51;
      end else if (shift) begin
         ok = ok && (imm < 32);
         v = v + f7 * 33554432 + longint'(imm % 32) * 1048576 + 19;
      end else begin
         s = longint'($signed(imm));
         ok = ok && (s >= -2048) && (s <= 2047);
         v = v + ((s + 4096) % 4096) * 1048576 + 19;
      end
      w = v[31:0];
   endfunction

   // Advance one clock edge and update the model from the inputs present at that edge.
   task automatic tick();
      bit acc, pop, lg;
      logic [31:0] w;
      acc = req_valid && (exp_q.size() < DEPTH);
      pop = (exp_q.size() > 0) && out_ready;
      ref_encode(req_is_imm, req_alu_control, req_rd, req_rs1, req_rs2, req_imm, lg, w);
      @(posedge clk);
      #1;
      if (rst) begin
         exp_q.delete();
         m_addr = RESET_ADDR;
         m_err = 0;
         m_cnt = 0;
      end else begin
         if (pop) void'(exp_q.pop_front());
         if (acc && lg) exp_q.push_back(w);
         m_err = acc && !lg;
         if (m_err && m_cnt < 255) m_cnt++;
         if (base_load) m_addr = base_addr;
         else if (pop) m_addr = m_addr + 32'd4;
      end
   endtask

   task automatic set_req(input bit v, input bit im, input logic [3:0] c,
                          input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                          input logic [31:0] iv);
      req_valid = v; req_is_imm = im; req_alu_control = c;
      req_rd = d; req_rs1 = s1; req_rs2 = s2; req_imm = iv;
   endtask

   task automatic do_reset();
      rst = 1'b1; req_valid = 1'b0; base_load = 1'b0; base_addr = '0; out_ready = 1'b0;
      set_req(0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
      n_total++; if (out_inst !== 32'h0) $display("FAIL reset_out_inst got=%h exp=0", out_inst); else n_pass++;
      n_total++; if (out_addr !== RESET_ADDR) $display("FAIL reset_out_addr got=%h exp=%h", out_addr, RESET_ADDR); else n_pass++;
      n_total++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else n_pass++;
      n_total++; if (err_count !== 8'd0) $display("FAIL reset_err_count got=%0d exp=0", err_count); else n_pass++;
      n_total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got=%b exp=1", req_ready); else n_pass++;
   endtask

   task automatic test_itype();
      do_reset();
      out_ready = 1'b1;
      set_req(1, 1, 4'b0010, 5'd1, 5'd0, 5'd0, 32'd5);
      tick();
      req_valid = 1'b0;
      n_total++; if (out_valid !== 1'b1) $display("FAIL addi_valid got=%b exp=1", out_valid); else n_pass++;
      n_total++; if (out_inst !== 32'h00500093) $display("FAIL addi_inst got=%h exp=00500093", out_inst); else n_pass++;
      n_total++; if (out_addr !== 32'h0) $display("FAIL addi_addr got=%h exp=0", out_addr); else n_pass++;
      tick();
      n_total++; if (out_valid !== 1'b0) $display("FAIL addi_drain got=%b exp=0", out_valid); else n_pass++;
      n_total++; if (out_addr !== 32'h4) $display("FAIL addi_next_addr got=%h exp=4", out_addr); else n_pass++;
   endtask

   task automatic test_r_pair();
      do_reset();
      out_ready = 1'b1;
      set_req(1, 0, 4'b0010, 5'd3, 5'd1, 5'd2, 32'd0);
      tick();
      n_total++; if (out_inst !== 32'h002081B3) $display("FAIL add_inst got=%h exp=002081B3", out_inst); else n_pass++;
      n_total++; if (out_addr !== 32'h0) $display("FAIL add_addr got=%h exp=0", out_addr); else n_pass++;
      set_req(1, 0, 4'b0100, 5'd3, 5'd1, 5'd2, 32'd0);
      tick();
      req_valid = 1'b0;
      n_total++; if (out_inst !== 32'h402081B3) $display("FAIL sub_inst got=%h exp=402081B3", out_inst); else n_pass++;
      n_total++; if (out_addr !== 32'h4) $display("FAIL sub_addr got=%h exp=4", out_addr); else n_pass++;
      tick();
   endtask

   task automatic test_shift_neg();
      do_reset();
      out_ready = 1'b1;
      set_req(1, 1, 4'b1001, 5'd5, 5'd6, 5'd0, 32'd3);
      tick();
      n_total++; if (out_inst !== 32'h40335293) $display("FAIL srai_inst got=%h exp=40335293", out_inst); else n_pass++;
      set_req(1, 1, 4'b0110, 5'd1, 5'd1, 5'd0, 32'hFFFF_FFFF);
      tick();
      req_valid = 1'b0;
      n_total++; if (out_inst !== 32'hFFF0C093) $display("FAIL xori_inst got=%h exp=FFF0C093", out_inst); else n_pass++;
      n_total++; if (out_addr !== 32'h4) $display("FAIL xori_addr got=%h exp=4", out_addr); else n_pass++;
      tick();
   endtask

   task automatic test_illegal();
      logic [31:0] imms [3];
      logic [3:0]  ctls [3];
      bit          isi  [3];
      imms = '{32'd2048, 32'd32, 32'd0};
      ctls = '{4'b0010, 4'b0001, 4'b1000};
      isi  = '{1'b1, 1'b1, 1'b0};
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_req(1, isi[i], ctls[i], 5'd2, 5'd3, 5'd4, imms[i]);
         n_total++; if (req_ready !== 1'b1) $display("FAIL illegal_ready[%0d] got=%b exp=1", i, req_ready); else n_pass++;
         tick();
         req_valid = 1'b0;
         n_total++; if (err !== 1'b1) $display("FAIL illegal_err[%0d] got=%b exp=1", i, err); else n_pass++;
         n_total++; if (out_valid !== 1'b0) $display("FAIL illegal_noout[%0d] got=%b exp=0", i, out_valid); else n_pass++;
         tick();
         n_total++; if (err !== 1'b0) $display("FAIL illegal_pulse[%0d] got=%b exp=0", i, err); else n_pass++;
      end
      n_total++; if (err_count !== 8'd3) $display("FAIL illegal_count got=%0d exp=3", err_count); else n_pass++;
   endtask

   task automatic test_saturate();
      do_reset();
      set_req(1, 0, 4'b1111, 5'd0, 5'd0, 5'd0, 32'd0);
      for (int i = 0; i < 260; i++) tick();
      n_total++; if (err !== 1'b1) $display("FAIL sat_err got=%b exp=1", err); else n_pass++;
      n_total++; if (err_count !== 8'd255) $display("FAIL sat_count got=%0d exp=255", err_count); else n_pass++;
      req_valid = 1'b0;
      tick();
      n_total++; if (err_count !== 8'd255) $display("FAIL sat_hold got=%0d exp=255", err_count); else n_pass++;
   endtask

   task automatic test_backpressure();
      logic [31:0] w [5];
      bit acc;
      do_reset();
      for (int k = 0; k < 5; k++) w[k] = ((k + 1) << 20) | ((k + 1) << 7) | 32'h13;
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         set_req(1, 1, 4'b0010, 5'(k + 1), 5'd0, 5'd0, 32'(k + 1));
         n_total++;
         if (req_ready !== (k < 4)) $display("FAIL bp_ready[%0d] got=%b exp=%b", k, req_ready, k < 4);
         else n_pass++;
         tick();
      end
      n_total++; if (req_ready !== 1'b0) $display("FAIL bp_still_full got=%b exp=0", req_ready); else n_pass++;
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         n_total++; if (out_valid !== 1'b1) $display("FAIL bp_valid[%0d] got=%b exp=1", k, out_valid); else n_pass++;
         n_total++; if (out_inst !== w[k]) $display("FAIL bp_inst[%0d] got=%h exp=%h", k, out_inst, w[k]); else n_pass++;
         n_total++; if (out_addr !== 32'(4 * k)) $display("FAIL bp_addr[%0d] got=%h exp=%h", k, out_addr, 4 * k); else n_pass++;
         acc = req_valid && req_ready;
         tick();
         if (acc) req_valid = 1'b0;
      end
      n_total++; if (out_valid !== 1'b0) $display("FAIL bp_empty got=%b exp=0", out_valid); else n_pass++;
   endtask

   task automatic test_load();
      do_reset();
      out_ready = 1'b0;
      set_req(1, 1, 4'b0010, 5'd1, 5'd0, 5'd0, 32'd1);
      tick();
      set_req(1, 1, 4'b0010, 5'd1, 5'd0, 5'd0, 32'd2);
      tick();
      req_valid = 1'b0;
      base_load = 1'b1; base_addr = 32'h100; out_ready = 1'b1;
      tick();
      base_load = 1'b0;
      n_total++; if (out_addr !== 32'h100) $display("FAIL load_addr got=%h exp=00000100", out_addr); else n_pass++;
      n_total++; if (out_inst !== 32'h00200093) $display("FAIL load_inst got=%h exp=00200093", out_inst); else n_pass++;
      tick();
      n_total++; if (out_addr !== 32'h104) $display("FAIL load_next got=%h exp=00000104", out_addr); else n_pass++;
   endtask

   task automatic test_reset_stream();
      do_reset();
      out_ready = 1'b0;
      set_req(1, 0, 4'b0010, 5'd1, 5'd2, 5'd3, 32'd0);
      tick();
      tick();
      req_valid = 1'b0;
      base_load = 1'b1; base_addr = 32'h40;
      tick();
      base_load = 1'b0;
      n_total++; if (out_valid !== 1'b1) $display("FAIL rs_pre_valid got=%b exp=1", out_valid); else n_pass++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_total++; if (out_valid !== 1'b0) $display("FAIL rs_valid got=%b exp=0", out_valid); else n_pass++;
      n_total++; if (out_inst !== 32'h0) $display("FAIL rs_inst got=%h exp=0", out_inst); else n_pass++;
      n_total++; if (out_addr !== RESET_ADDR) $display("FAIL rs_addr got=%h exp=%h", out_addr, RESET_ADDR); else n_pass++;
      n_total++; if (req_ready !== 1'b1) $display("FAIL rs_ready got=%b exp=1", req_ready); else n_pass++;
   endtask

   task automatic test_random();
      logic [3:0]  legal_ctl [10];
      logic [31:0] bounds [6];
      logic [31:0] iv;
      logic [31:0] exp_inst;
      int bad;
      legal_ctl = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
      bounds = '{32'd2047, 32'd2048, 32'hFFFF_F800, 32'hFFFF_F7FF, 32'd31, 32'd32};
      bad = 0;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         case ($urandom_range(0, 3))
            0: iv = 32'($urandom_range(0, 31));
            1: iv = 32'($urandom_range(0, 4095)) - 32'd2048;
            2: iv = $urandom();
            default: iv = bounds[$urandom_range(0, 5)];
         endcase
         set_req($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 4) != 0) ? legal_ctl[$urandom_range(0, 9)]
                                             : 4'($urandom_range(0, 15)),
                 5'($urandom), 5'($urandom), 5'($urandom), iv);
         out_ready = $urandom_range(0, 2) != 0;
         base_load = $urandom_range(0, 15) == 0;
         base_addr = $urandom();
         if ($urandom_range(0, 49) == 0) base_addr = 32'hFFFF_FFFC;
         tick();
         exp_inst = (exp_q.size() > 0) ? exp_q[0] : 32'h0;
         n_total++;
         if (out_valid !== (exp_q.size() > 0) || out_inst !== exp_inst || out_addr !== m_addr) begin
            bad++;
            $display("FAIL rand_out cyc=%0d valid=%b/%b inst=%h/%h addr=%h/%h", c, out_valid,
                     exp_q.size() > 0, out_inst, exp_inst, out_addr, m_addr);
         end else n_pass++;
         n_total++;
         if (err !== m_err || err_count !== 8'(m_cnt) || req_ready !== (exp_q.size() < DEPTH)) begin
            bad++;
            $display("FAIL rand_ctl cyc=%0d err=%b/%b cnt=%0d/%0d ready=%b/%b", c, err, m_err,
                     err_count, m_cnt, req_ready, exp_q.size() < DEPTH);
         end else n_pass++;
         if (bad > 10) break;
      end
      req_valid = 1'b0;
      base_load = 1'b0;
   endtask

   initial begin
      test_reset();
      test_itype();
      test_r_pair();
      test_shift_neg();
      test_illegal();
      test_saturate();
      test_backpressure();
      test_load();
      test_reset_stream();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
